// File: rtl/audio_i2s_sched.sv
// Audio frame scheduler and I2S serializer: buffers stereo samples in a
// 2-entry FIFO, derives BCK from clk with a runtime divider and shifts out
// left-justified 32-bit frames (L then R, MSB first) with volume scaling.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | serializer stopped, bck/ws/din low, counters parked at frame end
// RUN   | BCK running, frames loaded at each bit_cnt wrap (falling edge)
module audio_i2s_sched #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] bck_div,
  input  logic [1:0]       volume,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [15:0]      sample_l,
  input  logic [15:0]      sample_r,
  output logic             i2s_bck,
  output logic             i2s_ws,
  output logic             i2s_din,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      frame;
  logic [31:0]      last_frame;

  logic [31:0]      fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_count;

  logic             run_step;
  logic             tick;
  logic             fall;
  logic [4:0]       bit_nxt;
  logic             load;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [31:0]      load_raw;
  logic [31:0]      frame_nxt;

  // Arithmetic shift with sign fill; volume 0 mutes.
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [1:0] vol);
    logic signed [15:0] x;
    x = s;
    case (vol)
      2'd0:    return 16'h0000;
      2'd1:    return 16'(x >>> 2);
      2'd2:    return 16'(x >>> 1);
      default: return s;
    endcase
  endfunction

  assign sample_ready = (fifo_count < DEPTH);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the per-cycle strobes that drive the datapath.
  always_comb begin
    state_nxt  = state;
    run_step   = 1'b0;
    tick       = 1'b0;
    fall       = 1'b0;
    bit_nxt    = bit_cnt + 5'd1;
    load       = 1'b0;
    fifo_empty = (fifo_count == 2'd0);
    push       = sample_valid && sample_ready;
    pop        = 1'b0;
    load_raw   = last_frame;
    frame_nxt  = 32'h0;

    case (state)
      S_IDLE: if (enable)  state_nxt = S_RUN;
      S_RUN:  if (!enable) state_nxt = S_IDLE;
      default:             state_nxt = S_IDLE;
    endcase

    run_step = (state == S_RUN) && enable;
    // >= rather than == so a lowered divider takes effect immediately.
    tick     = (div_cnt >= bck_div);
    fall     = run_step && tick && i2s_bck;
    load     = fall && (bit_nxt == 5'd0);
    pop      = load && !fifo_empty;

    if (!fifo_empty) load_raw = fifo_mem[rd_ptr];
    frame_nxt = {scale(load_raw[31:16], volume), scale(load_raw[15:0], volume)};
  end

  // Sample FIFO pointers and occupancy; enable does not touch the contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {sample_l, sample_r};
  end

  // BCK divider, bit sequencing, frame loads and underrun accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= 5'd31;
      i2s_bck      <= 1'b0;
      i2s_ws       <= 1'b0;
      i2s_din      <= 1'b0;
      frame        <= 32'h0;
      last_frame   <= 32'h0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'h00;
    end else begin
      underrun <= 1'b0;
      if (!run_step) begin
        div_cnt <= '0;
        bit_cnt <= 5'd31;
        i2s_bck <= 1'b0;
        i2s_ws  <= 1'b0;
        i2s_din <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        i2s_bck <= ~i2s_bck;
        if (fall) begin
          bit_cnt <= bit_nxt;
          i2s_ws  <= bit_nxt[4];
          if (load) begin
            frame   <= frame_nxt;
            i2s_din <= frame_nxt[31];
            if (fifo_empty) begin
              underrun <= 1'b1;
              if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
            end else begin
              last_frame <= load_raw;
            end
          end else begin
            i2s_din <= frame[5'd31 - bit_nxt];
          end
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_sched.sv
// Bench for audio_i2s_sched: accepted sample pairs go into a scoreboard
// queue; every frame load seen on the I2S pins pops (or repeats) and the
// serialized word, ws pattern and underrun reporting are compared.
module tb_audio_i2s_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  bck_div = 8'd3;
  logic [1:0]  volume = 2'd3;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] sample_l = 16'h0;
  logic [15:0] sample_r = 16'h0;
  logic        i2s_bck, i2s_ws, i2s_din, underrun;
  logic [7:0]  underrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  audio_i2s_sched #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bck_div      (bck_div),
    .volume       (volume),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .i2s_bck      (i2s_bck),
    .i2s_ws       (i2s_ws),
    .i2s_din      (i2s_din),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [1:0] v);
    case (v)
      2'd0:    return 16'h0000;
      2'd1:    return {{2{s[15]}}, s[15:2]};
      2'd2:    return {s[15], s[15:1]};
      default: return s;
    endcase
  endfunction

  // scoreboard / reference model state
  logic [31:0] sb_q[$];
  logic [31:0] m_last = 32'h0;
  int          m_ucnt = 0;
  logic [4:0]  m_bit = 5'd31;
  bit          active = 1'b0;
  logic [31:0] exp_frame = 32'h0;
  logic [31:0] rx_d = 32'h0;
  logic [31:0] rx_w = 32'h0;
  int          frames_done = 0;

  // values seen at the previous negedge, i.e. what the last posedge captured
  logic        p_rst = 1'b1;
  logic        p_en = 1'b0;
  logic        p_bck = 1'b0;
  logic        p_push = 1'b0;
  logic [1:0]  p_vol = 2'd3;
  logic [31:0] p_data = 32'h0;

  // Monitor: evaluate the effect of the posedge just passed, then sample.
  always @(negedge clk) begin
    logic exp_u;
    exp_u = 1'b0;
    if (p_rst) begin
      sb_q.delete();
      m_last = 32'h0;
      m_ucnt = 0;
      m_bit  = 5'd31;
      active = 1'b0;
      check_eq("rst_bck", i2s_bck, 0);
      check_eq("rst_ws", i2s_ws, 0);
      check_eq("rst_din", i2s_din, 0);
      check_eq("rst_underrun", underrun, 0);
      check_eq("rst_ucnt", underrun_cnt, 0);
    end else begin
      if (!p_en) begin
        m_bit  = 5'd31;
        active = 1'b0;
        check_eq("idle_bck", i2s_bck, 0);
        check_eq("idle_ws", i2s_ws, 0);
        check_eq("idle_din", i2s_din, 0);
      end else if (p_bck && !i2s_bck) begin
        m_bit = m_bit + 5'd1;
        if (m_bit == 5'd0) begin
          if (sb_q.size() != 0) m_last = sb_q.pop_front();
          else begin
            exp_u = 1'b1;
            if (m_ucnt < 255) m_ucnt++;
          end
          exp_frame = {ref_scale(m_last[31:16], p_vol), ref_scale(m_last[15:0], p_vol)};
          active = 1'b1;
          rx_d = 32'h0;
          rx_w = 32'h0;
          check_eq("ucnt", underrun_cnt, m_ucnt);
        end
        if (active) begin
          rx_d = {rx_d[30:0], i2s_din};
          rx_w = {rx_w[30:0], i2s_ws};
          if (m_bit == 5'd31) begin
            check_eq("frame_data", rx_d, exp_frame);
            check_eq("frame_ws", rx_w, 32'h0000FFFF);
            frames_done++;
          end
        end
      end else if (!active) begin
        check_eq("pre_din", i2s_din, 0);
        check_eq("pre_ws", i2s_ws, 0);
      end
      check_eq("underrun", underrun, exp_u);
      if (p_push) sb_q.push_back(p_data);
    end
    check_eq("ready", sample_ready, sb_q.size() < 2);
    p_rst  = reset;
    p_en   = enable;
    p_bck  = i2s_bck;
    p_vol  = volume;
    p_push = sample_valid && sample_ready;
    p_data = {sample_l, sample_r};
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    while (!acc && guard < 5000) begin
      @(negedge clk);
      acc = sample_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("push_accept", acc, 1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target;
    int guard;
    target = frames_done + n;
    guard = 0;
    while (frames_done < target && guard < 40000) begin
      step(1);
      guard++;
    end
    check_eq("frames_wait", frames_done >= target, 1);
  endtask

  task automatic wait_bit(input logic [4:0] b);
    int guard;
    guard = 0;
    while (!(active && m_bit == b) && guard < 5000) begin
      step(1);
      guard++;
    end
    check_eq("bit_wait", active && m_bit == b, 1);
  endtask

  initial begin
    step(4);
    reset = 1'b0;
    step(2);

    // fill FIFO while stopped; third pair must wait for the first load
    push_pair(16'h8001, 16'h7FFE);
    push_pair(16'h1234, 16'hABCD);
    check_eq("ready_full", sample_ready, 0);
    fork
      push_pair(16'h5555, 16'hAAAA);
      enable = 1'b1;
    join
    wait_frames(5);

    // underrun repetition and counter saturation at a fast BCK
    bck_div = 8'd0;
    wait_frames(300);
    check_eq("ucnt_sat", underrun_cnt, 255);

    // volume scaling, then mute with ws still running
    volume = 2'd1;
    push_pair(16'h8000, 16'h4001);
    wait_frames(3);
    volume = 2'd0;
    wait_frames(2);
    volume = 2'd3;

    // enable drop mid-frame keeps FIFO contents
    bck_div = 8'd2;
    push_pair(16'h0F0F, 16'hF0F0);
    push_pair(16'h3C3C, 16'hC3C3);
    wait_bit(5'd10);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    wait_frames(3);

    // push on the same cycle as a pop with one entry buffered
    bck_div = 8'd0;
    wait_frames(1);
    push_pair(16'h1111, 16'h2222);
    begin
      int guard;
      guard = 0;
      while (!(i2s_bck && active && m_bit == 5'd31) && guard < 5000) begin
        step(1);
        guard++;
      end
      check_eq("align_wait", i2s_bck && active && m_bit == 5'd31, 1);
    end
    sample_l = 16'h6666;
    sample_r = 16'h9999;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    check_eq("cnt1_ready", sample_ready, 1);
    wait_frames(3);

    // reset mid-frame, with a push attempt in the reset cycle
    push_pair(16'h7777, 16'h8888);
    wait_bit(5'd5);
    reset = 1'b1;
    sample_l = 16'h4242;
    sample_r = 16'h2424;
    sample_valid = 1'b1;
    step(1);
    reset = 1'b0;
    sample_valid = 1'b0;
    check_eq("rst_ready", sample_ready, 1);
    wait_frames(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
